// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache refill path.
// PC layout: [1:0] byte offset, [5:2] line index, [WIDTH-1:6] tag.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  localparam int INDEX_LSB = 2;
  localparam int INDEX_MSB = 5;
  localparam int TAG_LSB   = 6;
  localparam int IDX_W     = INDEX_MSB - INDEX_LSB + 1;
  localparam int MISS_CNT_W = 16;

endpackage

// File: rtl/icache_line_array.sv
// One-word-per-line storage: data/tag arrays without reset, valid bits cleared by reset or flush.
// Reads are combinational; a single synchronous write port installs a refilled line.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LINES = 16,
  parameter int TAG_W = WIDTH - TAG_LSB
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic             rd_valid_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             clr_i
);

  logic [WIDTH-1:0] data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

  // A clear and a write never coincide: the controller suppresses the fill when flushing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache front end: same-cycle hit lookup, single outstanding
// refill request, saturating miss counter.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LINES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      PC,
  input  logic                  fetch_valid,
  input  logic                  flush,
  output logic [WIDTH-1:0]      instruction,
  output logic                  instr_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic [WIDTH-1:0]      mem_addr,
  input  logic                  mem_ack,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int TAG_W = WIDTH - TAG_LSB;

  function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                state_q;
  logic [WIDTH-1:0]      miss_addr_q;
  logic [WIDTH-1:0]      miss_addr_d;
  logic [MISS_CNT_W-1:0] miss_count_q;
  logic [MISS_CNT_W-1:0] miss_count_d;
  logic                  mem_req_q;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [WIDTH-1:0] line_data;
  logic [TAG_W-1:0] line_tag;
  logic             line_valid;
  logic             hit;
  logic             in_idle;
  logic             miss_take;
  logic             fill_we;
  logic             pc_offset_unused;

  assign rd_idx           = PC[INDEX_MSB:INDEX_LSB];
  assign pc_tag           = PC[WIDTH-1:TAG_LSB];
  assign pc_offset_unused = ^PC[INDEX_LSB-1:0];

  assign hit          = fetch_valid & line_valid & (line_tag == pc_tag);
  assign in_idle      = (state_q == IDLE);
  assign miss_take    = in_idle & fetch_valid & ~hit & ~flush;
  assign miss_addr_d  = {PC[WIDTH-1:INDEX_LSB], 2'b00};
  assign miss_count_d = sat_inc(miss_count_q);

  // A flush coinciding with the ack wins: the returning data predates the flush.
  assign fill_we = (state_q == REQ) & mem_ack & ~flush;

  icache_line_array #(
    .WIDTH (WIDTH),
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_lines (
    .CLK        (CLK),
    .RST        (RST),
    .rd_idx_i   (rd_idx),
    .rd_data_o  (line_data),
    .rd_tag_o   (line_tag),
    .rd_valid_o (line_valid),
    .wr_en_i    (fill_we),
    .wr_idx_i   (miss_addr_q[INDEX_MSB:INDEX_LSB]),
    .wr_tag_i   (miss_addr_q[WIDTH-1:TAG_LSB]),
    .wr_data_i  (mem_rdata),
    .clr_i      (flush)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      miss_addr_q  <= '0;
      miss_count_q <= '0;
      mem_req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss_take) begin
            state_q      <= REQ;
            miss_addr_q  <= miss_addr_d;
            miss_count_q <= miss_count_d;
            mem_req_q    <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q   <= flush ? IDLE : FILL;
            mem_req_q <= 1'b0;
          end
        end
        FILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Outside IDLE the fetch is always held; RST masks the combinational hit/miss path.
  assign instruction = line_data;
  assign instr_valid = ~RST & in_idle & hit;
  assign stall       = ~RST & (in_idle ? (fetch_valid & ~hit) : 1'b1);
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_req_q ? miss_addr_q : '0;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed and randomized stimulus for icache_refill_ctrl, checked against a line-level cache model.
module tb_icache_refill_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] miss_count;

  always #5 CLK = ~CLK;

  icache_refill_ctrl #(.WIDTH(32), .LINES(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC          (PC),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .miss_count  (miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Cache contents as seen by software, plus the refill bookkeeping.
  bit          m_valid   [16];
  bit          m_written [16];
  logic [25:0] m_tag     [16];
  logic [31:0] m_data    [16];
  bit          waiting;
  bit          bubble;
  logic [31:0] m_addr;
  int          m_cnt;

  // Outputs observed during the most recent step (before its clock edge).
  logic        o_iv, o_stall, o_req;
  logic [31:0] o_instr, o_addr;
  logic [15:0] o_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    waiting = 1'b0;
    bubble  = 1'b0;
    m_addr  = 32'h0;
    m_cnt   = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    PC = 32'h0; fetch_valid = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    RST = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_miss_count", miss_count, 16'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    fetch_valid = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [31:0] pc, input bit fv, input bit fl, input bit ack,
                      input logic [31:0] rd);
    int idx;
    bit hit;
    bit idle;
    @(negedge CLK);
    PC = pc; fetch_valid = fv; flush = fl; mem_ack = ack; mem_rdata = rd;
    #1;
    o_iv = instr_valid; o_stall = stall; o_req = mem_req;
    o_instr = instruction; o_addr = mem_addr; o_cnt = miss_count;
    idx  = int'(pc[5:2]);
    idle = !waiting && !bubble;
    hit  = fv && m_valid[idx] && (m_tag[idx] == pc[31:6]);
    chk("instr_valid", instr_valid, idle && hit);
    chk("stall", stall, idle ? (fv && !hit) : 1'b1);
    chk("mem_req", mem_req, waiting);
    chk("mem_addr", mem_addr, waiting ? m_addr : 32'h0);
    chk("miss_count", miss_count, m_cnt[15:0]);
    if (m_written[idx]) chk("instruction", instruction, m_data[idx]);
    @(posedge CLK);
    if (fl) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    if (idle) begin
      if (fv && !hit && !fl) begin
        waiting = 1'b1;
        m_addr  = {pc[31:2], 2'b00};
        if (m_cnt < 65535) m_cnt++;
      end
    end else if (waiting) begin
      if (ack) begin
        waiting = 1'b0;
        if (!fl) begin
          idx = int'(m_addr[5:2]);
          m_valid[idx]   = 1'b1;
          m_written[idx] = 1'b1;
          m_tag[idx]     = m_addr[31:6];
          m_data[idx]    = rd;
          bubble         = 1'b1;
        end
      end
    end else begin
      bubble = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] pc_r;
    RST = 1'b0; PC = 32'h0; fetch_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_written[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    model_reset();
    #2;
    do_reset();

    // Cold miss at 0x0 and its refill.
    step(32'h0, 1, 0, 0, 32'h0);
    chk("cold_stall", o_stall, 1'b1);
    step(32'h0, 1, 0, 0, 32'h0);
    chk("req_mem_req", o_req, 1'b1);
    chk("req_mem_addr", o_addr, 32'h0);
    chk("req_miss_count", o_cnt, 16'd1);
    step(32'h0, 1, 0, 1, 32'h00006137);
    step(32'h0, 1, 0, 0, 32'h0);
    chk("fill_stall", o_stall, 1'b1);
    chk("fill_instr_valid", o_iv, 1'b0);
    step(32'h0, 1, 0, 0, 32'h0);
    chk("hit_instr_valid", o_iv, 1'b1);
    chk("hit_instruction", o_instr, 32'h00006137);
    chk("hit_stall", o_stall, 1'b0);

    // Conflict on index 1: 0x04 then 0x44 evicts it, 0x04 misses again.
    do_reset();
    step(32'h04, 1, 0, 0, 32'h0);
    step(32'h04, 1, 0, 1, 32'hAAAA0004);
    step(32'h04, 1, 0, 0, 32'h0);
    step(32'h04, 1, 0, 0, 32'h0);
    chk("p04_hit", o_iv, 1'b1);
    step(32'h44, 1, 0, 0, 32'h0);
    chk("p44_miss", o_stall, 1'b1);
    step(32'h44, 1, 0, 1, 32'hBBBB0044);
    step(32'h44, 1, 0, 0, 32'h0);
    step(32'h44, 1, 0, 0, 32'h0);
    chk("p44_instruction", o_instr, 32'hBBBB0044);
    step(32'h04, 1, 0, 0, 32'h0);
    chk("p04_remiss", o_iv, 1'b0);
    step(32'h04, 1, 0, 1, 32'hAAAA0004);
    chk("conflict_miss_count", o_cnt, 16'd3);
    step(32'h04, 1, 0, 0, 32'h0);

    // Flush together with ack: nothing installed, refetch misses.
    step(32'h08, 1, 0, 0, 32'h0);
    step(32'h08, 1, 1, 1, 32'hCCCC0008);
    step(32'h08, 1, 0, 0, 32'h0);
    chk("flush_ack_remiss", o_stall, 1'b1);
    step(32'h08, 0, 0, 0, 32'h0);
    chk("flush_ack_req_addr", o_addr, 32'h08);
    step(32'h08, 0, 1, 0, 32'h0);
    step(32'h08, 0, 0, 1, 32'hDDDD0008);
    step(32'h08, 0, 0, 0, 32'h0);
    step(32'h0B, 1, 0, 0, 32'h0);
    chk("fill_after_flush_hit", o_iv, 1'b1);

    // PC wanders during REQ; the latched address is used.
    step(32'h10, 1, 0, 0, 32'h0);
    step(32'h99C, 1, 0, 0, 32'h0);
    chk("latched_addr", o_addr, 32'h10);
    step(32'h200, 1, 0, 1, 32'hEEEE0010);
    step(32'h300, 1, 0, 0, 32'h0);
    step(32'h10, 1, 0, 0, 32'h0);
    chk("latched_fill_hit", o_instr, 32'hEEEE0010);

    // RST mid-request; the late ack is ignored.
    step(32'h20, 1, 0, 0, 32'h0);
    @(negedge CLK);
    fetch_valid = 1'b0; mem_ack = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_miss_count", miss_count, 16'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    step(32'h20, 0, 0, 1, 32'h12345678);
    chk("late_ack_mem_req", o_req, 1'b0);
    step(32'h10, 1, 0, 0, 32'h0);
    chk("post_rst_invalid", o_iv, 1'b0);
    step(32'h10, 0, 1, 1, 32'h0);

    // Randomized traffic over a small address pool to mix hits, conflicts and flushes.
    for (int n = 0; n < 600; n++) begin
      pc_r = {24'h0, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom)};
      step(pc_r, ($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 3) == 0, $urandom);
    end

    // Saturation: 65535 misses from a clean counter, then one more.
    do_reset();
    for (int n = 0; n < 65535; n++) begin
      step(32'h0, 1, 0, 0, 32'h0);
      step(32'h0, 0, 1, 1, 32'h0);
    end
    step(32'h0, 0, 0, 0, 32'h0);
    chk("sat_reach", o_cnt, 16'hFFFF);
    step(32'h0, 1, 0, 0, 32'h0);
    step(32'h0, 0, 1, 1, 32'h0);
    chk("sat_hold", o_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
